// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle drawer: FSM encoding, datapath widths
// and the default paddle/erase colours.
package paddle_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned COL_W   = 3;

    localparam logic [COL_W-1:0] FG = 3'b100;
    localparam logic [COL_W-1:0] BG = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pixel_scan.sv
// Rectangle scan counters: qx runs 0..PW-1 fastest, then qy 0..PH-1.
// Ports: clk, resetn, clear (restart at pixel 0, wins over advance),
// advance (step to next pixel), qx/qy (current pixel), row_end_c (qx at
// last column), last_c (current pixel is the final one of the rectangle).
module pixel_scan
    import paddle_pkg::*;
#(
    parameter int unsigned PW = 20,
    parameter int unsigned PH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] qx,
    output logic [ROW_W-1:0]   qy,
    output logic               row_end_c,
    output logic               last_c
);

    localparam logic [COORD_W-1:0] QX_LAST = COORD_W'(PW - 1);
    localparam logic [ROW_W-1:0]   QY_LAST = ROW_W'(PH - 1);

    always_comb begin
        row_end_c = (qx == QX_LAST);
        last_c    = row_end_c && (qy == QY_LAST);
    end

    // Column counter wraps into the row counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qx <= '0;
            qy <= '0;
        end else if (clear) begin
            qx <= '0;
            qy <= '0;
        end else if (advance) begin
            if (row_end_c) begin
                qx <= '0;
                qy <= qy + ROW_W'(1);
            end else begin
                qx <= qx + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_drawer.sv
// Paddle position tracker and redraw engine. Moves the paddle on enable
// ticks and, on a draw request, erases the previously drawn rectangle (only
// if the paddle moved) and draws it at the new position, one pixel a cycle.
// Ports: clk, resetn (async, active low); left/right/enable movement;
// draw start request; x/y/colour/writeEn pixel stream (registered);
// busy during ERASE/DRAW; done one-cycle completion pulse; pos_x paddle edge.
module paddle_drawer #(
    parameter int unsigned PW       = 20,
    parameter int unsigned PH       = 2,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned Y_POS    = 64,
    parameter int unsigned X_INIT   = 32,
    parameter int unsigned STEP     = 1,
    parameter logic [2:0]  FG       = paddle_pkg::FG,
    parameter logic [2:0]  BG       = paddle_pkg::BG
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       left,
    input  logic       right,
    input  logic       enable,
    input  logic       draw,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done,
    output logic [9:0] pos_x
);

    import paddle_pkg::*;

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(SCREEN_W - PW);
    localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_BASE = COORD_W'(Y_POS);
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

    state_e             state, state_d;
    logic [COORD_W-1:0] draw_x, draw_x_d;
    logic [COORD_W-1:0] old_x, old_x_d;
    logic               drawn_valid, drawn_valid_d;
    logic [COORD_W-1:0] x_d, y_d;
    logic [2:0]         colour_d;
    logic               we_d, busy_d, done_d;
    logic               scan_clr, scan_adv;
    logic [COORD_W-1:0] qx;
    logic [ROW_W-1:0]   qy;
    logic               row_end_c, last_c;
    logic [COORD_W:0]   pos_sum_c;

    pixel_scan #(.PW(PW), .PH(PH)) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (scan_clr),
        .advance   (scan_adv),
        .qx        (qx),
        .qy        (qy),
        .row_end_c (row_end_c),
        .last_c    (last_c)
    );

    // Movement with clamping; one extra bit keeps the right-hand sum exact.
    always_comb pos_sum_c = {1'b0, pos_x} + (COORD_W+1)'(STEP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_x <= X_RST;
        end else if (enable && left && !right) begin
            pos_x <= (pos_x < STEP_C) ? '0 : pos_x - STEP_C;
        end else if (enable && right && !left) begin
            pos_x <= (pos_sum_c > {1'b0, X_MAX}) ? X_MAX : pos_sum_c[COORD_W-1:0];
        end
    end

    // State and registered pixel outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            draw_x      <= X_RST;
            old_x       <= X_RST;
            drawn_valid <= 1'b0;
            x           <= X_RST;
            y           <= Y_BASE;
            colour      <= BG;
            writeEn     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            draw_x      <= draw_x_d;
            old_x       <= old_x_d;
            drawn_valid <= drawn_valid_d;
            x           <= x_d;
            y           <= y_d;
            colour      <= colour_d;
            writeEn     <= we_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next state plus the pixel that will be presented after the edge.
    always_comb begin
        state_d       = state;
        draw_x_d      = draw_x;
        old_x_d       = old_x;
        drawn_valid_d = drawn_valid;
        x_d           = x;
        y_d           = y;
        colour_d      = colour;
        we_d          = 1'b0;
        done_d        = 1'b0;
        scan_clr      = 1'b0;
        scan_adv      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (draw) begin
                    draw_x_d = pos_x;
                    scan_clr = 1'b1;
                    we_d     = 1'b1;
                    y_d      = Y_BASE;
                    if (drawn_valid && (pos_x != old_x)) begin
                        state_d  = ST_ERASE;
                        x_d      = old_x;
                        colour_d = BG;
                    end else begin
                        state_d  = ST_DRAW;
                        x_d      = pos_x;
                        colour_d = FG;
                    end
                end
            end
            ST_ERASE: begin
                we_d = 1'b1;
                if (last_c) begin
                    // Straight into DRAW so the write stream has no gap.
                    state_d  = ST_DRAW;
                    scan_clr = 1'b1;
                    x_d      = draw_x;
                    y_d      = Y_BASE;
                    colour_d = FG;
                end else begin
                    scan_adv = 1'b1;
                    if (row_end_c) begin
                        x_d = old_x;
                        y_d = y + COORD_W'(1);
                    end else begin
                        x_d = x + COORD_W'(1);
                    end
                end
            end
            ST_DRAW: begin
                if (last_c) begin
                    state_d       = ST_DONE;
                    done_d        = 1'b1;
                    old_x_d       = draw_x;
                    drawn_valid_d = 1'b1;
                end else begin
                    we_d     = 1'b1;
                    scan_adv = 1'b1;
                    if (row_end_c) begin
                        x_d = draw_x;
                        y_d = y + COORD_W'(1);
                    end else begin
                        x_d = x + COORD_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ERASE) || (state_d == ST_DRAW);
    end

endmodule

// File: tb/tb_paddle_drawer.sv
// Self-checking bench for paddle_drawer: movement vector table, directed
// redraw sequences and randomized movement/draw traffic against a model
// that predicts pos_x arithmetically and each redraw as a list of pixels.
module tb_paddle_drawer;

    localparam int PW = 20;
    localparam int PH = 2;
    localparam int SCREEN_W = 160;
    localparam int Y_POS = 64;
    localparam int X_INIT = 32;
    localparam int STEP = 1;
    localparam int FGV = 4;
    localparam int BGV = 0;
    localparam int XMAX = SCREEN_W - PW;

    logic       clk = 1'b0;
    logic       resetn;
    logic       left, right, enable, draw;
    logic [9:0] x, y, pos_x;
    logic [2:0] colour;
    logic       writeEn, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    int m_pos, m_old;
    bit m_valid;
    int ex_x[$];
    int ex_y[$];
    int ex_c[$];

    typedef struct {
        bit en;
        bit l;
        bit r;
        int exp_pos;
    } mv_vec_t;

    mv_vec_t vt[8];

    paddle_drawer #(
        .PW(PW), .PH(PH), .SCREEN_W(SCREEN_W), .Y_POS(Y_POS),
        .X_INIT(X_INIT), .STEP(STEP), .FG(3'b100), .BG(3'b000)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .left    (left),
        .right   (right),
        .enable  (enable),
        .draw    (draw),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .writeEn (writeEn),
        .busy    (busy),
        .done    (done),
        .pos_x   (pos_x)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mv(input int p, input bit en, input bit l, input bit r);
        if (en && l && !r) return (p < STEP) ? 0 : p - STEP;
        if (en && r && !l) return (p + STEP > XMAX) ? XMAX : p + STEP;
        return p;
    endfunction

    // One clock; the model applies the movement inputs seen at this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        m_pos = mv(m_pos, enable, left, right);
        chk("pos_x", int'(pos_x), m_pos);
    endtask

    task automatic quiet();
        enable = 1'b0;
        left   = 1'b0;
        right  = 1'b0;
    endtask

    task automatic rand_moves();
        enable = 1'($urandom_range(0, 1));
        left   = 1'($urandom_range(0, 1));
        right  = 1'($urandom_range(0, 1));
    endtask

    // mode 0: quiet, 1: random moves and stray draws, 2: draw pulse mid-redraw
    task automatic run_draw(input int mode, output int nw);
        int dx;
        int n;
        ex_x.delete();
        ex_y.delete();
        ex_c.delete();
        dx = m_pos;
        if (m_valid && dx != m_old) begin
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++) begin
                    ex_x.push_back(m_old + c);
                    ex_y.push_back(Y_POS + r);
                    ex_c.push_back(BGV);
                end
        end
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++) begin
                ex_x.push_back(dx + c);
                ex_y.push_back(Y_POS + r);
                ex_c.push_back(FGV);
            end
        n  = ex_x.size();
        nw = 0;
        draw = 1'b1;
        if (mode == 1) rand_moves(); else quiet();
        tick();
        draw = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (writeEn) nw++;
            chk("writeEn", int'(writeEn), 1);
            chk("x", int'(x), ex_x[i]);
            chk("y", int'(y), ex_y[i]);
            chk("colour", int'(colour), ex_c[i]);
            chk("busy", int'(busy), 1);
            chk("done_early", int'(done), 0);
            if (mode == 1) begin
                rand_moves();
                draw = ($urandom_range(0, 7) == 0);
            end else if (mode == 2) begin
                draw = (i == 20);
            end else begin
                quiet();
                draw = 1'b0;
            end
            tick();
        end
        chk("done_pulse", int'(done), 1);
        chk("we_in_done", int'(writeEn), 0);
        chk("busy_in_done", int'(busy), 0);
        draw = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        draw = 1'b0;
        chk("done_single", int'(done), 0);
        chk("we_after_done", int'(writeEn), 0);
        chk("busy_after_done", int'(busy), 0);
        m_old   = dx;
        m_valid = 1'b1;
    endtask

    initial begin
        int nw;
        vt[0] = '{en: 1'b0, l: 1'b1, r: 1'b0, exp_pos: 32};
        vt[1] = '{en: 1'b1, l: 1'b1, r: 1'b0, exp_pos: 31};
        vt[2] = '{en: 1'b1, l: 1'b0, r: 1'b1, exp_pos: 32};
        vt[3] = '{en: 1'b1, l: 1'b1, r: 1'b1, exp_pos: 32};
        vt[4] = '{en: 1'b1, l: 1'b0, r: 1'b0, exp_pos: 32};
        vt[5] = '{en: 1'b0, l: 1'b0, r: 1'b1, exp_pos: 32};
        vt[6] = '{en: 1'b1, l: 1'b0, r: 1'b1, exp_pos: 33};
        vt[7] = '{en: 1'b1, l: 1'b1, r: 1'b0, exp_pos: 32};

        resetn = 1'b0;
        draw   = 1'b0;
        quiet();
        m_pos   = X_INIT;
        m_old   = X_INIT;
        m_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_writeEn", int'(writeEn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_colour", int'(colour), BGV);
        chk("rst_x", int'(x), X_INIT);
        chk("rst_y", int'(y), Y_POS);
        chk("rst_pos_x", int'(pos_x), X_INIT);
        @(negedge clk);
        resetn = 1'b1;

        // Movement vector table
        for (int i = 0; i < 8; i++) begin
            enable = vt[i].en;
            left   = vt[i].l;
            right  = vt[i].r;
            tick();
            chk("vec_pos", int'(pos_x), vt[i].exp_pos);
        end
        quiet();

        // First draw after reset: draw only
        run_draw(0, nw);
        chk("first_draw_writes", nw, 40);

        // No move since last draw: no erase
        run_draw(0, nw);
        chk("nomove_writes", nw, 40);

        // Three right ticks then redraw with erase
        enable = 1'b1;
        right  = 1'b1;
        repeat (3) tick();
        quiet();
        chk("pos_after_3right", int'(pos_x), 35);
        run_draw(0, nw);
        chk("move_writes", nw, 80);

        // Draw pulsed mid-DRAW is ignored
        run_draw(2, nw);
        chk("middraw_writes", nw, 40);

        // Clamping at both ends
        enable = 1'b1;
        left   = 1'b1;
        repeat (40) tick();
        chk("clamp_left", int'(pos_x), 0);
        left  = 1'b0;
        right = 1'b1;
        repeat (150) tick();
        chk("clamp_right", int'(pos_x), XMAX);
        tick();
        chk("clamp_right_hold", int'(pos_x), 140);
        quiet();

        // Randomized traffic
        for (int it = 0; it < 25; it++) begin
            int k;
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                rand_moves();
                tick();
            end
            run_draw(1, nw);
        end
        quiet();

        // Reset in the middle of a redraw
        draw = 1'b1;
        tick();
        draw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("pre_rst_we", int'(writeEn), 1);
            tick();
        end
        resetn = 1'b0;
        #1;
        chk("midrst_we", int'(writeEn), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_pos", int'(pos_x), 32);
        chk("midrst_x", int'(x), 32);
        chk("midrst_y", int'(y), 64);
        m_pos   = X_INIT;
        m_old   = X_INIT;
        m_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
        right  = 1'b1;
        repeat (2) tick();
        quiet();
        run_draw(0, nw);
        chk("post_rst_writes", nw, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
